wb_regfile_stage: RTL

Write-back end of the 2-stage pipelined datapath: captures the EXE stage result (ALU output, destination address, write enable) into an EXE/WB register, commits it to a 16-entry x 16-bit register file, and serves the ID-stage read ports with full hazard bypassing. It pairs with the IF/ID and EXE pipeline: that pipeline reads operands and produces `aluout`; this block writes them back and makes them visible to the next decoded instruction without stalls.

---
 rtl/wb_regfile_stage.sv | 76 +++++++
 1 files changed

// File: rtl/wb_regfile_stage.sv
// Write-back stage: EXE/WB pipeline register, 2^AW x DW register file with R0 hardwired to zero,
// and two read ports with EXE-then-WB bypass so a result can be used the cycle it is produced.
module wb_regfile_stage #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wen_exe,
  input  logic [AW-1:0] i_waddr_exe,
  input  logic [DW-1:0] i_aluout_exe,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2,
  output logic          o_wen_wb,
  output logic [AW-1:0] o_waddr_wb,
  output logic [DW-1:0] o_wdata_wb,
  output logic [15:0]   o_retired
);

  localparam int NREG = 1 << AW;

  logic          r_wen_wb;
  logic [AW-1:0] r_waddr_wb;
  logic [DW-1:0] r_wdata_wb;
  logic [15:0]   r_retired;
  logic [DW-1:0] r_regs [NREG];
  logic          w_commit;

  assign w_commit = r_wen_wb && (r_waddr_wb != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wen_wb   <= 1'b0;
      r_waddr_wb <= '0;
      r_wdata_wb <= '0;
      r_retired  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_wen_wb   <= i_wen_exe;
      r_waddr_wb <= i_waddr_exe;
      r_wdata_wb <= i_aluout_exe;
      if (w_commit) begin
        r_regs[r_waddr_wb] <= r_wdata_wb;
        r_retired          <= r_retired + 16'd1;
      end
    end
  end

  // Youngest producer wins: EXE result, then the one waiting in WB, then the array.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == '0)                           v = '0;
    else if (i_wen_exe && i_waddr_exe == a) v = i_aluout_exe;
    else if (r_wen_wb && r_waddr_wb == a)   v = r_wdata_wb;
    else                                    v = r_regs[a];
    return v;
  endfunction

  logic [DW-1:0] w_rdata1;
  logic [DW-1:0] w_rdata2;

  always_comb begin
    w_rdata1 = read_port(i_raddr1);
    w_rdata2 = read_port(i_raddr2);
  end

  assign o_rdata1   = w_rdata1;
  assign o_rdata2   = w_rdata2;
  assign o_wen_wb   = r_wen_wb;
  assign o_waddr_wb = r_waddr_wb;
  assign o_wdata_wb = r_wdata_wb;
  assign o_retired  = r_retired;

endmodule
